// File: rtl/core_s2_operand_stage.sv
// ALU operand-select stage: resolves RAW forwarding, muxes operand sources and
// holds the result in a one-entry valid/ready register, plus a saved-rs2 slot for two-pass atomics.
module core_s2_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [1:0]                op1_src,
    input  logic [2:0]                op2_src,
    input  logic [XLEN-1:0]           rs1,
    input  logic [XLEN-1:0]           rs2,
    input  logic [4:0]                rs1_idx,
    input  logic [4:0]                rs2_idx,
    input  logic [XLEN-1:0]           current_pc,
    input  logic [XLEN-1:0]           immediate,
    input  logic [XLEN-1:0]           csr_data_out,
    input  logic [XLEN-1:0]           dcache_data_out,
    input  logic                      amo_capture,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*5-1:0]      fwd_rd_idx,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           alu_operand_1,
    output logic [XLEN-1:0]           alu_operand_2,
    output logic                      saved_rs2_valid,
    output logic                      src_err
);

    localparam logic [1:0] OP1_RS1    = 2'd0;
    localparam logic [1:0] OP1_PC     = 2'd1;
    localparam logic [1:0] OP1_DCACHE = 2'd2;
    localparam logic [1:0] OP1_ZERO   = 2'd3;

    localparam logic [2:0] OP2_RS2       = 3'd0;
    localparam logic [2:0] OP2_IMM       = 3'd1;
    localparam logic [2:0] OP2_CSR       = 3'd2;
    localparam logic [2:0] OP2_SAVED_RS2 = 3'd3;
    localparam logic [2:0] OP2_CONST4    = 3'd4;

    localparam logic [XLEN-1:0] CONST4_VAL = XLEN'(3'd4);

    logic            out_valid_r;
    logic [XLEN-1:0] op1_r;
    logic [XLEN-1:0] op2_r;
    logic [XLEN-1:0] saved_rs2_r;
    logic            saved_rs2_valid_r;
    logic            src_err_r;

    logic            acc_s;
    logic            in_ready_s;
    logic [XLEN-1:0] rs1_eff_s;
    logic [XLEN-1:0] rs2_eff_s;
    logic [XLEN-1:0] op1_mux_s;
    logic [XLEN-1:0] op2_mux_s;
    logic            op2_err_s;

    // Lowest-index (youngest) matching port wins; x0 is never forwarded.
    function automatic logic [XLEN-1:0] resolve_fwd(
        input logic [4:0]              idx,
        input logic [XLEN-1:0]         reg_val,
        input logic [NUM_FWD-1:0]      v,
        input logic [NUM_FWD*5-1:0]    rd,
        input logic [NUM_FWD*XLEN-1:0] d
    );
        logic [XLEN-1:0] res;
        logic            hit;
        logic            match;
        res = reg_val;
        hit = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            match = (idx != 5'd0) && v[i] && (rd[i*5 +: 5] == idx);
            res   = (match && !hit) ? d[i*XLEN +: XLEN] : res;
            hit   = hit | match;
        end
        return res;
    endfunction

    // Handshake: in_ready never depends on in_valid.
    always_comb begin
        in_ready_s = ~flush & (~out_valid_r | out_ready);
        acc_s      = in_valid & in_ready_s;
    end

    // Effective register operands after forwarding.
    always_comb begin
        rs1_eff_s = resolve_fwd(rs1_idx, rs1, fwd_valid, fwd_rd_idx, fwd_data);
        rs2_eff_s = resolve_fwd(rs2_idx, rs2, fwd_valid, fwd_rd_idx, fwd_data);
    end

    // Operand 1 source select.
    always_comb begin
        op1_mux_s = '0;
        case (op1_src)
            OP1_RS1:    op1_mux_s = rs1_eff_s;
            OP1_PC:     op1_mux_s = current_pc;
            OP1_DCACHE: op1_mux_s = dcache_data_out;
            OP1_ZERO:   op1_mux_s = '0;
            default:    op1_mux_s = '0;
        endcase
    end

    // Operand 2 source select; SAVED_RS2 reads the pre-capture value.
    always_comb begin
        op2_mux_s = '0;
        op2_err_s = 1'b0;
        case (op2_src)
            OP2_RS2:       op2_mux_s = rs2_eff_s;
            OP2_IMM:       op2_mux_s = immediate;
            OP2_CSR:       op2_mux_s = csr_data_out;
            OP2_SAVED_RS2: begin
                op2_mux_s = saved_rs2_r;
                op2_err_s = ~saved_rs2_valid_r;
            end
            OP2_CONST4:    op2_mux_s = CONST4_VAL;
            default: begin
                op2_mux_s = '0;
                op2_err_s = 1'b1;
            end
        endcase
    end

    // Output valid register: accept sets, drain clears, flush kills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (acc_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Operand registers load only on accept, so held operands are stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_r <= '0;
            op2_r <= '0;
        end else if (acc_s) begin
            op1_r <= op1_mux_s;
            op2_r <= op2_mux_s;
        end else begin
            op1_r <= op1_r;
            op2_r <= op2_r;
        end
    end

    // Saved rs2 for two-pass atomics; survives consumption, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_rs2_r       <= '0;
            saved_rs2_valid_r <= 1'b0;
        end else if (flush) begin
            saved_rs2_r       <= '0;
            saved_rs2_valid_r <= 1'b0;
        end else if (acc_s && amo_capture) begin
            saved_rs2_r       <= rs2_eff_s;
            saved_rs2_valid_r <= 1'b1;
        end else begin
            saved_rs2_r       <= saved_rs2_r;
            saved_rs2_valid_r <= saved_rs2_valid_r;
        end
    end

    // Sticky source-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_err_r <= 1'b0;
        end else if (acc_s && op2_err_s) begin
            src_err_r <= 1'b1;
        end else begin
            src_err_r <= src_err_r;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign alu_operand_1   = op1_r;
    assign alu_operand_2   = op2_r;
    assign saved_rs2_valid = saved_rs2_valid_r;
    assign src_err         = src_err_r;

endmodule

// File: tb/tb_core_s2_operand_stage.sv
// Bench for core_s2_operand_stage: directed test-plan steps followed by random
// traffic, all checked against a transaction-level reference model.
module tb_core_s2_operand_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [1:0]              op1_src;
    logic [2:0]              op2_src;
    logic [XLEN-1:0]         rs1, rs2;
    logic [4:0]              rs1_idx, rs2_idx;
    logic [XLEN-1:0]         current_pc, immediate, csr_data_out, dcache_data_out;
    logic                    amo_capture;
    logic [NUM_FWD-1:0]      fwd_valid;
    logic [NUM_FWD*5-1:0]    fwd_rd_idx;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         alu_operand_1, alu_operand_2;
    logic                    saved_rs2_valid;
    logic                    src_err;

    int checks;
    int failures;

    // Reference model state
    logic            m_valid;
    logic [XLEN-1:0] m_op1, m_op2, m_saved;
    logic            m_saved_valid;
    logic            m_err;

    core_s2_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .op1_src(op1_src), .op2_src(op2_src),
        .rs1(rs1), .rs2(rs2), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .current_pc(current_pc), .immediate(immediate),
        .csr_data_out(csr_data_out), .dcache_data_out(dcache_data_out),
        .amo_capture(amo_capture), .fwd_valid(fwd_valid),
        .fwd_rd_idx(fwd_rd_idx), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .saved_rs2_valid(saved_rs2_valid), .src_err(src_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd_ref(input logic [4:0] idx, input logic [XLEN-1:0] regval);
        if (idx == 5'd0) return regval;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (fwd_valid[i] && fwd_rd_idx[i*5 +: 5] == idx) return fwd_data[i*XLEN +: XLEN];
        end
        return regval;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_saved = '0;
        m_saved_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, "_saved_valid"}, 64'(saved_rs2_valid), 64'(m_saved_valid));
        chk({tag, "_src_err"}, 64'(src_err), 64'(m_err));
        if (m_valid) begin
            chk({tag, "_op1"}, 64'(alu_operand_1), 64'(m_op1));
            chk({tag, "_op2"}, 64'(alu_operand_2), 64'(m_op2));
        end
    endtask

    // One clock: check in_ready, advance the model, clock the DUT, compare.
    task automatic cycle(input string tag);
        logic            rdy;
        logic            acc;
        logic [XLEN-1:0] e1, e2;
        #1;
        rdy = !flush && (!m_valid || out_ready);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(rdy));
        acc = in_valid && rdy;
        if (flush) begin
            m_valid = 1'b0; m_saved_valid = 1'b0; m_saved = '0;
        end else if (acc) begin
            e1 = fwd_ref(rs1_idx, rs1);
            e2 = fwd_ref(rs2_idx, rs2);
            case (op1_src)
                2'd0: m_op1 = e1;
                2'd1: m_op1 = current_pc;
                2'd2: m_op1 = dcache_data_out;
                default: m_op1 = '0;
            endcase
            case (op2_src)
                3'd0: m_op2 = e2;
                3'd1: m_op2 = immediate;
                3'd2: m_op2 = csr_data_out;
                3'd3: m_op2 = m_saved;
                3'd4: m_op2 = 32'd4;
                default: m_op2 = '0;
            endcase
            if (op2_src > 3'd4 || (op2_src == 3'd3 && !m_saved_valid)) m_err = 1'b1;
            m_valid = 1'b1;
            if (amo_capture) begin
                m_saved = e2; m_saved_valid = 1'b1;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; op1_src = 2'd0; op2_src = 3'd0;
        rs1 = '0; rs2 = '0; rs1_idx = 5'd0; rs2_idx = 5'd0;
        current_pc = '0; immediate = '0; csr_data_out = '0; dcache_data_out = '0;
        amo_capture = 1'b0; fwd_valid = '0; fwd_rd_idx = '0; fwd_data = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_op1", 64'(alu_operand_1), 64'd0);
        chk("reset_op2", 64'(alu_operand_2), 64'd0);
        chk("reset_saved_valid", 64'(saved_rs2_valid), 64'd0);
        chk("reset_src_err", 64'(src_err), 64'd0);
        rst_n = 1'b1;

        // Basic: PC + CONST4
        in_valid = 1'b1; op1_src = 2'd1; current_pc = 32'h8000_0010; op2_src = 3'd4;
        cycle("basic");
        chk("basic_op1_const", 64'(alu_operand_1), 64'h8000_0010);
        chk("basic_op2_const", 64'(alu_operand_2), 64'd4);

        // Forward priority
        op1_src = 2'd0; op2_src = 3'd1; immediate = 32'h77;
        rs1_idx = 5'd5; rs1 = 32'h11; fwd_valid = 2'b11;
        fwd_rd_idx = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        cycle("fwd_prio");
        chk("fwd_prio_const", 64'(alu_operand_1), 64'hAA);
        rs1_idx = 5'd0; fwd_rd_idx = {5'd0, 5'd0};
        cycle("fwd_x0");
        chk("fwd_x0_const", 64'(alu_operand_1), 64'h11);
        fwd_valid = '0;

        // Backpressure
        rs1_idx = 5'd1; rs1 = 32'h1;
        cycle("bp_a");
        rs1 = 32'h2; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp_hold");
            chk("bp_hold_op1_const", 64'(alu_operand_1), 64'h1);
        end
        out_ready = 1'b1;
        cycle("bp_b");
        chk("bp_b_op1_const", 64'(alu_operand_1), 64'h2);
        in_valid = 1'b0;
        cycle("bp_drain");

        // Atomic two-pass
        in_valid = 1'b1; amo_capture = 1'b1; op2_src = 3'd0;
        rs2_idx = 5'd7; rs2 = 32'h1234; fwd_valid = 2'b01; fwd_rd_idx = {5'd0, 5'd7};
        fwd_data = {32'h0, 32'h5678};
        cycle("amo_p1");
        chk("amo_p1_saved_const", 64'(saved_rs2_valid), 64'd1);
        amo_capture = 1'b0; fwd_valid = '0; op1_src = 2'd2; dcache_data_out = 32'h9; op2_src = 3'd3;
        cycle("amo_p2");
        chk("amo_p2_op1_const", 64'(alu_operand_1), 64'h9);
        chk("amo_p2_op2_const", 64'(alu_operand_2), 64'h5678);

        // Flush, then SAVED_RS2 with nothing saved
        flush = 1'b1;
        cycle("flush");
        chk("flush_valid_const", 64'(out_valid), 64'd0);
        flush = 1'b0;
        cycle("flush_err");
        chk("flush_err_const", 64'(src_err), 64'd1);

        // Reset mid-stream
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_op1", 64'(alu_operand_1), 64'd0);
        chk("rst_mid_op2", 64'(alu_operand_2), 64'd0);
        chk("rst_mid_saved", 64'(saved_rs2_valid), 64'd0);
        chk("rst_mid_err", 64'(src_err), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        idle_inputs();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            op1_src     = 2'($urandom_range(0, 3));
            op2_src     = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rs1         = $urandom; rs2 = $urandom;
            rs1_idx     = 5'($urandom_range(0, 3));
            rs2_idx     = 5'($urandom_range(0, 3));
            current_pc  = $urandom; immediate = $urandom;
            csr_data_out = $urandom; dcache_data_out = $urandom;
            amo_capture = ($urandom_range(0, 3) == 0);
            fwd_valid   = 2'($urandom_range(0, 3));
            fwd_rd_idx  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_data    = {32'($urandom), 32'($urandom)};
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_s2_operand_stage.md
# core_s2_operand_stage

Registered, parametrised ALU operand-select stage in core stage 2, between decode/register read and the ALU. Selects operand 1 and operand 2 from register, PC, immediate, CSR, dcache and constant sources. Applies RAW forwarding from `NUM_FWD` later-stage write ports and holds a saved-rs2 register for two-pass atomics. Results go through a one-entry valid/ready output register, with flush support.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_FWD`, 2, number of forwarding sources; index 0 is the youngest and has the highest priority.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept.
- `flush`  in  1  kill the held and incoming instruction, and clear saved rs2.
- `op1_src`  in  2  0=RS1, 1=PC, 2=DCACHE, 3=ZERO (`core_pkg::alu_op1_src_e` values).
- `op2_src`  in  3  0=RS2, 1=IMM, 2=CSR, 3=SAVED_RS2, 4=CONST4, 5..7 reserved (`core_pkg::alu_op2_src_e` values).
- `rs1`, `rs2`  in  XLEN  register-file read data.
- `rs1_idx`, `rs2_idx`  in  5  architectural source indices.
- `current_pc`, `immediate`, `csr_data_out`, `dcache_data_out`  in  XLEN  source data.
- `amo_capture`  in  1  on accept, latch the effective rs2 into saved rs2.
- `fwd_valid`  in  NUM_FWD  forwarding port valid.
- `fwd_rd_idx`  in  NUM_FWD×5  forwarding destination index.
- `fwd_data`  in  NUM_FWD×XLEN  forwarding data.
- `out_valid`  out  1  operands valid.
- `out_ready`  in  1  ALU accepts.
- `alu_operand_1`, `alu_operand_2`  out  XLEN  registered operands.
- `saved_rs2_valid`  out  1  saved rs2 holds a captured value.
- `src_err`  out  1  sticky flag: a reserved op2 encoding, or SAVED_RS2 selected while `saved_rs2_valid`=0, was accepted.

## Operation
- Effective rs1:
  - If `rs1_idx`≠0 and any `fwd_valid[i]` has `fwd_rd_idx[i]`==`rs1_idx`, use `fwd_data` of the lowest such i.
  - Otherwise use `rs1`.
  - Effective rs2 is formed the same way.
  - Index 0 is never forwarded.
- Operand 1:
  - RS1 → effective rs1.
  - PC → `current_pc`.
  - DCACHE → `dcache_data_out`.
  - ZERO → 0.
- Operand 2:
  - RS2 → effective rs2.
  - IMM → `immediate`.
  - CSR → `csr_data_out`.
  - SAVED_RS2 → saved register.
  - CONST4 → 4, zero-extended to XLEN.
  - Reserved encodings → 0 and set `src_err`.
- Accept: `acc = in_valid & in_ready`, where `in_ready = ~flush & (~out_valid | out_ready)`.
- On `acc`:
  - The operand registers load the muxed values.
  - `out_valid` is set to 1.
  - If `amo_capture`, saved rs2 loads effective rs2 and `saved_rs2_valid` is set to 1.
- On `out_valid & out_ready & ~acc` (and no flush): `out_valid` is set to 0.
- Operands hold their value while `out_valid & ~out_ready` and must not change.
- `flush`:
  - `out_valid`, `saved_rs2_valid` ← 0.
  - No accept occurs that cycle.
  - Operand registers are not required to clear.
- Saved rs2 lifetime:
  - It persists until overwritten by another capture or cleared by flush.
  - Consuming it via SAVED_RS2 does not clear it.
  - Capture and SAVED_RS2 selection in the same accept: operand 2 uses the *old* saved value, and the register takes the new one.
- `src_err`: set on an erroneous accept, cleared only by reset.

## Timing
- Reset values (async assert, sync-free deassert):
  - `out_valid`=0, `saved_rs2_valid`=0, `src_err`=0.
  - `alu_operand_1`=`alu_operand_2`=0, saved rs2=0.
  - `in_ready`=1 after reset (combinational).
- Latency: one cycle; operands accepted at edge N are visible at `out_valid` after edge N.
- Throughput: one per cycle while `out_ready`=1. A simultaneous drain and accept keeps `out_valid`=1 with no bubble.
- `in_ready` is combinational on `out_valid`, `out_ready` and `flush`. There is no combinational path from `in_valid` to `in_ready`.
- Forwarding is sampled only in the accept cycle; later `fwd_*` changes do not affect held operands.
- Reset mid-transaction discards held operands and the saved value immediately.

## Test plan
- Basic: `op1_src`=PC, `current_pc`=0x8000_0010, `op2_src`=CONST4, `out_ready`=1 → next cycle `alu_operand_1`=0x8000_0010, `alu_operand_2`=4, `out_valid`=1.
- Forward priority:
  - `rs1_idx`=5, `rs1`=0x11, fwd0 and fwd1 both valid for rd 5 with 0xAA and 0xBB → operand 1 = 0xAA.
  - `rs1_idx`=0 with a matching fwd for rd 0 → operand 1 = `rs1`.
- Backpressure: accept A (rs1=0x1), hold `out_ready`=0 for 3 cycles while presenting B → `in_ready`=0, operands stay 0x1. Raising `out_ready` gives B the next cycle with no gap.
- Atomic two-pass:
  - Pass 1: accept with `amo_capture`=1, rs2=0x1234 forwarded as 0x5678 → `saved_rs2_valid`=1.
  - Pass 2: `op1_src`=DCACHE (0x9), `op2_src`=SAVED_RS2 → operands 0x9 / 0x5678.
- Flush: flush while `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0 and `saved_rs2_valid`=0. A following SAVED_RS2 accept sets `src_err`=1.
- Reset mid-stream: drop `rst_n` asynchronously with `out_valid`=1 → all outputs 0 immediately, `in_ready`=1.
